// File: rtl/sdram_arb_pkg.sv
// Shared command encodings, requester indices and FSM state type
// for the SDRAM request arbiter and its neighbours.
package sdram_arb_pkg;

  localparam logic [1:0] CMD_NOP     = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_READ    = 2'b10;
  localparam logic [1:0] CMD_REFRESH = 2'b11;

  localparam logic [1:0] REQ_GEIG = 2'd0;
  localparam logic [1:0] REQ_MAG  = 2'd1;
  localparam logic [1:0] REQ_RD   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_COMPLETE
  } state_t;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == REQ_RD) ? REQ_GEIG : idx + 2'd1;
  endfunction

  // Search starts just after the last granted requester.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] last,
    input logic [2:0] req
  );
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = rr_next(last);
    c2 = rr_next(c1);
    if (req[c1]) return c1;
    if (req[c2]) return c2;
    return last;
  endfunction

endpackage

// File: rtl/sdram_arb_refresh_scheduler.sv
// Auto-refresh interval timer with a saturating pending counter
// and a sticky overrun flag.
module refresh_scheduler #(
  parameter int REFRESH_INTERVAL = 360
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_served,
  output logic pending_nz,
  output logic overrun
);

  localparam int TW = $clog2(REFRESH_INTERVAL);

  logic [TW-1:0] timer;
  logic [2:0]    pending;
  logic          wrap;

  assign wrap       = (timer == TW'(REFRESH_INTERVAL - 1));
  assign pending_nz = |pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      timer <= wrap ? '0 : timer + 1'b1;
      // A wrap coinciding with a served refresh cancels out.
      if (wrap && !tick_served) begin
        if (pending == 3'd7) overrun <= 1'b1;
        else                 pending <= pending + 3'd1;
      end else if (!wrap && tick_served && pending != 3'd0) begin
        pending <= pending - 3'd1;
      end
    end
  end

endmodule

// File: rtl/sdram_request_arbiter.sv
// Round-robin arbiter for the SDRAM command port with
// highest-priority auto-refresh and accept-timeout handling.
module sdram_request_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 360,
  parameter int ACCEPT_TIMEOUT   = 15
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET,
  input  logic        SDRAM_STATUS,
  input  logic        GEIG_REQ,
  input  logic [1:0]  GEIG_BA,
  input  logic [12:0] GEIG_ROW,
  input  logic [8:0]  GEIG_COL,
  input  logic [15:0] GEIG_DATA,
  output logic        GEIG_DONE,
  input  logic        MAG_REQ,
  input  logic [1:0]  MAG_BA,
  input  logic [12:0] MAG_ROW,
  input  logic [8:0]  MAG_COL,
  input  logic [15:0] MAG_DATA,
  output logic        MAG_DONE,
  input  logic        RD_REQ,
  input  logic [1:0]  RD_BA,
  input  logic [12:0] RD_ROW,
  input  logic [8:0]  RD_COL,
  output logic        RD_DONE,
  output logic [1:0]  CMD_OUT,
  output logic [1:0]  BA_OUT,
  output logic [12:0] ROW_OUT,
  output logic [8:0]  COL_OUT,
  output logic [15:0] DATA_OUT,
  output logic        REFRESH_OVERRUN,
  output logic        CMD_ERROR
);

  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);

  state_t        state;
  logic [1:0]    last;
  logic [1:0]    cur;
  logic          cur_ref;
  logic [TW-1:0] tmo;
  logic [2:0]    reqs;
  logic [1:0]    pick;
  logic          ref_pending;
  logic          served;

  assign reqs   = {RD_REQ, MAG_REQ, GEIG_REQ};
  assign pick   = rr_pick(last, reqs);
  assign served = (state == ST_COMPLETE) && cur_ref;

  refresh_scheduler #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh (
    .clk        (CLK_48MHZ),
    .rst        (RESET),
    .tick_served(served),
    .pending_nz (ref_pending),
    .overrun    (REFRESH_OVERRUN)
  );

  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      last      <= REQ_RD;
      cur       <= REQ_GEIG;
      cur_ref   <= 1'b0;
      tmo       <= '0;
      CMD_OUT   <= CMD_NOP;
      BA_OUT    <= '0;
      ROW_OUT   <= '0;
      COL_OUT   <= '0;
      DATA_OUT  <= '0;
      GEIG_DONE <= 1'b0;
      MAG_DONE  <= 1'b0;
      RD_DONE   <= 1'b0;
      CMD_ERROR <= 1'b0;
    end else begin
      GEIG_DONE <= 1'b0;
      MAG_DONE  <= 1'b0;
      RD_DONE   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (SDRAM_STATUS && (ref_pending || |reqs)) begin
            state <= ST_ISSUE;
            tmo   <= '0;
            if (ref_pending) begin
              cur_ref  <= 1'b1;
              CMD_OUT  <= CMD_REFRESH;
              BA_OUT   <= '0;
              ROW_OUT  <= '0;
              COL_OUT  <= '0;
              DATA_OUT <= '0;
            end else begin
              cur_ref <= 1'b0;
              cur     <= pick;
              case (pick)
                REQ_MAG: begin
                  CMD_OUT  <= CMD_WRITE;
                  BA_OUT   <= MAG_BA;
                  ROW_OUT  <= MAG_ROW;
                  COL_OUT  <= MAG_COL;
                  DATA_OUT <= MAG_DATA;
                end
                REQ_RD: begin
                  CMD_OUT  <= CMD_READ;
                  BA_OUT   <= RD_BA;
                  ROW_OUT  <= RD_ROW;
                  COL_OUT  <= RD_COL;
                  DATA_OUT <= '0;
                end
                default: begin
                  CMD_OUT  <= CMD_WRITE;
                  BA_OUT   <= GEIG_BA;
                  ROW_OUT  <= GEIG_ROW;
                  COL_OUT  <= GEIG_COL;
                  DATA_OUT <= GEIG_DATA;
                end
              endcase
            end
          end
        end
        ST_ISSUE: begin
          if (!SDRAM_STATUS) begin
            state   <= ST_WAIT_DONE;
            CMD_OUT <= CMD_NOP;
          end else if (tmo == TW'(ACCEPT_TIMEOUT - 1)) begin
            // Abandon; the request stays pending and is retried.
            state     <= ST_IDLE;
            CMD_OUT   <= CMD_NOP;
            CMD_ERROR <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (SDRAM_STATUS) begin
            state <= ST_COMPLETE;
            if (!cur_ref) begin
              GEIG_DONE <= (cur == REQ_GEIG);
              MAG_DONE  <= (cur == REQ_MAG);
              RD_DONE   <= (cur == REQ_RD);
            end
          end
        end
        ST_COMPLETE: begin
          state <= ST_IDLE;
          if (!cur_ref) last <= cur;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Directed self-checking bench for sdram_request_arbiter with a
// behavioural SDRAM interface status responder.
module tb_sdram_request_arbiter;
  import sdram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        status;
  logic        geig_req, mag_req, rd_req;
  logic [1:0]  geig_ba, mag_ba, rd_ba;
  logic [12:0] geig_row, mag_row, rd_row;
  logic [8:0]  geig_col, mag_col, rd_col;
  logic [15:0] geig_data, mag_data;
  logic        geig_done, mag_done, rd_done;
  logic [1:0]  cmd_out, ba_out;
  logic [12:0] row_out;
  logic [8:0]  col_out;
  logic [15:0] data_out;
  logic        overrun, cmd_error;

  int compared = 0;
  int mismatched = 0;
  int mode = 0;
  int busy_n = 4;
  int busy_cnt = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [12:0] row;
    logic [15:0] data;
  } ent_t;

  ent_t iss_q[$];
  int   done_q[$];
  logic [1:0] prev_cmd;

  sdram_request_arbiter dut (
    .CLK_48MHZ      (clk),
    .RESET          (rst),
    .SDRAM_STATUS   (status),
    .GEIG_REQ       (geig_req),
    .GEIG_BA        (geig_ba),
    .GEIG_ROW       (geig_row),
    .GEIG_COL       (geig_col),
    .GEIG_DATA      (geig_data),
    .GEIG_DONE      (geig_done),
    .MAG_REQ        (mag_req),
    .MAG_BA         (mag_ba),
    .MAG_ROW        (mag_row),
    .MAG_COL        (mag_col),
    .MAG_DATA       (mag_data),
    .MAG_DONE       (mag_done),
    .RD_REQ         (rd_req),
    .RD_BA          (rd_ba),
    .RD_ROW         (rd_row),
    .RD_COL         (rd_col),
    .RD_DONE        (rd_done),
    .CMD_OUT        (cmd_out),
    .BA_OUT         (ba_out),
    .ROW_OUT        (row_out),
    .COL_OUT        (col_out),
    .DATA_OUT       (data_out),
    .REFRESH_OVERRUN(overrun),
    .CMD_ERROR      (cmd_error)
  );

  always #5 clk = ~clk;

  // Interface model: mode 0 accepts a command and stays busy for
  // busy_n cycles, mode 1 never accepts, mode 2 stays busy forever.
  initial begin
    status = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst || mode == 1) begin
        busy_cnt = 0;
        status = 1'b1;
      end else if (mode == 2) begin
        busy_cnt = 0;
        status = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) status = 1'b1;
      end else if (!status) begin
        status = 1'b1;
      end else if (cmd_out != CMD_NOP) begin
        status = 1'b0;
        busy_cnt = busy_n;
      end
    end
  end

  initial begin
    ent_t e;
    prev_cmd = CMD_NOP;
    forever begin
      @(posedge clk);
      #2;
      if (cmd_out != CMD_NOP && prev_cmd == CMD_NOP) begin
        e.cmd = cmd_out;
        e.row = row_out;
        e.data = data_out;
        iss_q.push_back(e);
      end
      prev_cmd = cmd_out;
      if (geig_done) done_q.push_back(0);
      if (mag_done) done_q.push_back(1);
      if (rd_done) done_q.push_back(2);
    end
  end

  task automatic do_reset;
    rst = 1'b1;
    geig_req = 1'b0;
    mag_req = 1'b0;
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int first;
    int db;
    rst = 1'b1;
    geig_req = 1'b0;
    mag_req = 1'b0;
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (cmd_out !== CMD_NOP) begin
      mismatched++;
      $display("FAIL reset_cmd: got %0h want 0", cmd_out);
    end
    compared++;
    if ({ba_out, row_out, col_out, data_out} !== 40'd0) begin
      mismatched++;
      $display("FAIL reset_bus: got row %0h data %0h want 0",
               row_out, data_out);
    end
    compared++;
    if ({geig_done, mag_done, rd_done} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_done: got %b want 000",
               {geig_done, mag_done, rd_done});
    end
    compared++;
    if ({overrun, cmd_error} !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_flags: got %b want 00", {overrun, cmd_error});
    end
    db = done_q.size();
    rst = 1'b0;
    first = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (cmd_out !== CMD_NOP) begin
        first = n;
        break;
      end
    end
    compared++;
    if (first != 361) begin
      mismatched++;
      $display("FAIL first_refresh_cycle: got %0d want 361", first);
    end
    compared++;
    if (cmd_out !== CMD_REFRESH) begin
      mismatched++;
      $display("FAIL first_refresh_cmd: got %0h want 3", cmd_out);
    end
    repeat (20) @(negedge clk);
    compared++;
    if (done_q.size() != db) begin
      mismatched++;
      $display("FAIL refresh_no_done: got %0d want 0", done_q.size() - db);
    end
    compared++;
    if (cmd_out !== CMD_NOP) begin
      mismatched++;
      $display("FAIL refresh_end_cmd: got %0h want 0", cmd_out);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0]  ec[4] = '{CMD_WRITE, CMD_WRITE, CMD_READ, CMD_WRITE};
    logic [12:0] er[4] = '{13'h111, 13'h222, 13'h333, 13'h111};
    int          ed[4] = '{0, 1, 2, 0};
    int ib;
    int db;
    int first_done;
    mode = 0;
    busy_n = 4;
    do_reset();
    ib = iss_q.size();
    db = done_q.size();
    geig_req = 1'b1;
    mag_req = 1'b1;
    rd_req = 1'b1;
    first_done = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (first_done == 0 && done_q.size() > db) first_done = n;
      if (done_q.size() - db >= 4) break;
    end
    geig_req = 1'b0;
    mag_req = 1'b0;
    rd_req = 1'b0;
    repeat (12) @(negedge clk);
    compared++;
    if (first_done != 6) begin
      mismatched++;
      $display("FAIL rr_first_done_cycle: got %0d want 6", first_done);
    end
    compared++;
    if (done_q.size() - db != 4) begin
      mismatched++;
      $display("FAIL rr_done_count: got %0d want 4", done_q.size() - db);
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (iss_q.size() <= ib + i || iss_q[ib+i].cmd !== ec[i] ||
          iss_q[ib+i].row !== er[i]) begin
        mismatched++;
        $display("FAIL rr_issue[%0d]: got cmd %0h row %0h want %0h %0h",
                 i, iss_q[ib+i].cmd, iss_q[ib+i].row, ec[i], er[i]);
      end
      compared++;
      if (done_q.size() <= db + i || done_q[db+i] != ed[i]) begin
        mismatched++;
        $display("FAIL rr_done[%0d]: got %0d want %0d",
                 i, done_q[db+i], ed[i]);
      end
    end
    compared++;
    if (iss_q[ib].data !== 16'hA1A1 || iss_q[ib+1].data !== 16'hB2B2) begin
      mismatched++;
      $display("FAIL rr_data: got %0h %0h want a1a1 b2b2",
               iss_q[ib].data, iss_q[ib+1].data);
    end
  endtask

  task automatic test_refresh_mid;
    logic [1:0]  ec[4] = '{CMD_WRITE, CMD_WRITE, CMD_REFRESH, CMD_READ};
    logic [12:0] er[4] = '{13'h111, 13'h222, 13'h000, 13'h333};
    int          ed[3] = '{0, 1, 2};
    int ib;
    int db;
    mode = 0;
    busy_n = 200;
    do_reset();
    ib = iss_q.size();
    db = done_q.size();
    geig_req = 1'b1;
    mag_req = 1'b1;
    rd_req = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done_q.size() - db >= 3) break;
    end
    geig_req = 1'b0;
    mag_req = 1'b0;
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (iss_q.size() <= ib + i || iss_q[ib+i].cmd !== ec[i] ||
          iss_q[ib+i].row !== er[i]) begin
        mismatched++;
        $display("FAIL refmid_issue[%0d]: got cmd %0h row %0h want %0h %0h",
                 i, iss_q[ib+i].cmd, iss_q[ib+i].row, ec[i], er[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (done_q.size() <= db + i || done_q[db+i] != ed[i]) begin
        mismatched++;
        $display("FAIL refmid_done[%0d]: got %0d want %0d",
                 i, done_q[db+i], ed[i]);
      end
    end
  endtask

  task automatic test_timeout;
    int wcnt;
    int db;
    mode = 1;
    busy_n = 4;
    do_reset();
    db = done_q.size();
    geig_req = 1'b1;
    wcnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cmd_error) break;
      if (cmd_out == CMD_WRITE) wcnt++;
    end
    compared++;
    if (cmd_error !== 1'b1) begin
      mismatched++;
      $display("FAIL tmo_error: got %b want 1", cmd_error);
    end
    compared++;
    if (cmd_out !== CMD_NOP) begin
      mismatched++;
      $display("FAIL tmo_cmd: got %0h want 0", cmd_out);
    end
    compared++;
    if (wcnt != 15) begin
      mismatched++;
      $display("FAIL tmo_issue_cycles: got %0d want 15", wcnt);
    end
    compared++;
    if (done_q.size() != db) begin
      mismatched++;
      $display("FAIL tmo_no_done: got %0d want 0", done_q.size() - db);
    end
    mode = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done_q.size() > db) break;
    end
    geig_req = 1'b0;
    compared++;
    if (done_q.size() != db + 1 || done_q[db] != 0) begin
      mismatched++;
      $display("FAIL tmo_retry_done: got %0d pulses want 1 geig",
               done_q.size() - db);
    end
    compared++;
    if (cmd_error !== 1'b1) begin
      mismatched++;
      $display("FAIL tmo_sticky: got %b want 1", cmd_error);
    end
  endtask

  task automatic test_overrun;
    int ib;
    int db;
    int nref;
    mode = 2;
    busy_n = 4;
    do_reset();
    repeat (8 * 360 + 5) @(negedge clk);
    compared++;
    if (overrun !== 1'b1) begin
      mismatched++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    compared++;
    if (cmd_out !== CMD_NOP || cmd_error !== 1'b0) begin
      mismatched++;
      $display("FAIL overrun_quiet: got cmd %0h err %b want 0 0",
               cmd_out, cmd_error);
    end
    ib = iss_q.size();
    db = done_q.size();
    geig_req = 1'b1;
    mode = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done_q.size() > db) break;
    end
    geig_req = 1'b0;
    nref = 0;
    for (int i = 0; i < 7; i++)
      if (iss_q.size() > ib + i && iss_q[ib+i].cmd == CMD_REFRESH) nref++;
    compared++;
    if (nref != 7) begin
      mismatched++;
      $display("FAIL overrun_refresh_burst: got %0d want 7", nref);
    end
    compared++;
    if (iss_q.size() <= ib + 7 || iss_q[ib+7].cmd !== CMD_WRITE ||
        iss_q[ib+7].row !== 13'h111) begin
      mismatched++;
      $display("FAIL overrun_then_write: got cmd %0h row %0h want 1 111",
               iss_q[ib+7].cmd, iss_q[ib+7].row);
    end
    compared++;
    if (overrun !== 1'b1) begin
      mismatched++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid;
    int db;
    mode = 0;
    busy_n = 20;
    do_reset();
    rd_req = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_out == CMD_READ) break;
    end
    repeat (4) @(negedge clk);
    compared++;
    if (row_out !== 13'h333) begin
      mismatched++;
      $display("FAIL rstmid_inflight_row: got %0h want 333", row_out);
    end
    db = done_q.size();
    rst = 1'b1;
    #1;
    compared++;
    if (cmd_out !== CMD_NOP || row_out !== 13'd0) begin
      mismatched++;
      $display("FAIL rstmid_async: got cmd %0h row %0h want 0 0",
               cmd_out, row_out);
    end
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    compared++;
    if (done_q.size() != db) begin
      mismatched++;
      $display("FAIL rstmid_no_done: got %0d want 0", done_q.size() - db);
    end
    compared++;
    if (cmd_out !== CMD_NOP) begin
      mismatched++;
      $display("FAIL rstmid_idle: got %0h want 0", cmd_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    geig_req = 1'b0;
    mag_req = 1'b0;
    rd_req = 1'b0;
    geig_ba = 2'd1;
    geig_row = 13'h111;
    geig_col = 9'h011;
    geig_data = 16'hA1A1;
    mag_ba = 2'd2;
    mag_row = 13'h222;
    mag_col = 9'h022;
    mag_data = 16'hB2B2;
    rd_ba = 2'd3;
    rd_row = 13'h333;
    rd_col = 9'h033;
    test_reset();
    test_round_robin();
    test_refresh_mid();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sdram_request_arbiter.md
# sdram_request_arbiter

Sits between the sensor write paths, the read-back path and `sdram_interface`, and owns the single SDRAM command port. It arbitrates round-robin among three requesters: Geiger write, magnetometer write and read-back. It also schedules periodic auto-refresh at highest priority. It sequences each command against the interface's `STATUS` handshake and reports per-requester completion.

## Interface
Parameters:
- `REFRESH_INTERVAL`, default 360: CLK_48MHZ cycles between refresh requests (≈7.5 µs, inside the 7.8 µs row budget).
- `ACCEPT_TIMEOUT`, default 15: cycles to wait for the interface to accept a command before aborting.

Ports (clock and reset first):
- `CLK_48MHZ`  in  1  system clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `SDRAM_STATUS`  in  1  1 = interface idle/ready, 0 = executing a command.
- `GEIG_REQ`  in  1  Geiger write request; held until `GEIG_DONE`.
- `GEIG_BA`  in  2  Geiger write bank address.
- `GEIG_ROW`  in  13  Geiger write row address.
- `GEIG_COL`  in  9  Geiger write column address.
- `GEIG_DATA`  in  16  Geiger write data.
- `GEIG_DONE`  out  1  one-cycle completion pulse.
- `MAG_REQ`, `MAG_BA`, `MAG_ROW`, `MAG_COL`, `MAG_DATA`, `MAG_DONE`: same widths and meaning for the magnetometer write.
- `RD_REQ`  in  1  read-back request.
- `RD_BA`  in  2  read bank address.
- `RD_ROW`  in  13  read row address.
- `RD_COL`  in  9  read column address.
- `RD_DONE`  out  1  one-cycle pulse; `DATA_READ` from `sdram_interface` is valid in that cycle.
- `CMD_OUT`  out  2  00 NOP, 01 WRITE, 10 READ, 11 REFRESH.
- `BA_OUT`  out  2  muxed bank address to `sdram_interface`.
- `ROW_OUT`  out  13  muxed row address to `sdram_interface`.
- `COL_OUT`  out  9  muxed column address to `sdram_interface`.
- `DATA_OUT`  out  16  muxed write data to `sdram_interface`.
- `REFRESH_OVERRUN`  out  1  sticky; set when the pending-refresh count saturates.
- `CMD_ERROR`  out  1  sticky; set on an accept timeout.

## Operation
- **States:**
  - IDLE → ISSUE when `SDRAM_STATUS`=1 and any request or refresh is pending.
  - ISSUE → WAIT_DONE when `SDRAM_STATUS`=0.
  - ISSUE → IDLE on timeout.
  - WAIT_DONE → COMPLETE when `SDRAM_STATUS`=1.
  - COMPLETE → IDLE unconditionally.
- **Selection in IDLE:**
  - Refresh wins whenever the pending count is nonzero.
  - Otherwise round-robin over GEIG → MAG → RD, starting after the last granted requester. The pointer updates only on COMPLETE of a requester command, not on refresh.
  - The winner's address and data are latched into output registers on IDLE→ISSUE. Later requester changes do not affect the command in flight.
- **ISSUE:**
  - `CMD_OUT` holds the command. It returns to NOP on the cycle the FSM leaves ISSUE.
  - The timeout counter counts ISSUE cycles. Reaching `ACCEPT_TIMEOUT` aborts: set `CMD_ERROR`, no DONE pulse, request remains pending, pointer unchanged.
- **COMPLETE:**
  - Pulse exactly one of the DONE outputs for the served requester. Refresh produces no DONE pulse.
  - A served refresh decrements the pending count.
- **Refresh timer:**
  - Free-running 0..`REFRESH_INTERVAL`−1. On wrap it increments a 3-bit pending count.
  - The count saturates at 7 and sets `REFRESH_OVERRUN`.
  - A wrap and a served-refresh decrement in the same cycle leave the count unchanged.
- A requester that drops REQ before grant is simply not served. A requester that drops REQ mid-command still gets its DONE pulse.
- **Reset values:** state IDLE; `CMD_OUT`=00; `BA_OUT`, `ROW_OUT`, `COL_OUT`, `DATA_OUT` = 0; all DONE=0; timer=0; pending=0; sticky flags=0; RR pointer=RD, so GEIG has first priority.
- Reset mid-command returns to IDLE immediately with outputs at reset values. No DONE is issued for the aborted command.

## Timing
- Minimum IDLE→DONE path, with an interface that drops `STATUS` one cycle after seeing the command:
  - cycle 0: select;
  - cycle 1: `CMD_OUT` valid;
  - cycle 2: `STATUS`=0 observed;
  - then N busy cycles;
  - DONE pulses one cycle after `STATUS` returns to 1.
- IDLE→ISSUE decision takes one cycle. A new command can start on the cycle after COMPLETE.
- All outputs are registered. No combinational path from any REQ to `CMD_OUT`.

## Structure
- Shared package `sdram_arb_pkg` holds:
  - `CMD_NOP`, `CMD_WRITE`, `CMD_READ`, `CMD_REFRESH` encodings (shared with `memory_controller` and `sdram_interface`);
  - requester index constants `REQ_GEIG`, `REQ_MAG`, `REQ_RD`;
  - the FSM state type.
- One sub-module, `refresh_scheduler`: the interval timer, saturating pending counter and overrun flag. Interface: `tick_served` in; `pending_nz` and `overrun` out.

## Test plan
- Reset, then idle with no requests → `CMD_OUT`=00 and all outputs 0 until the first refresh; after 360 cycles `CMD_OUT`=11; no DONE pulse.
- `GEIG_REQ`, `MAG_REQ` and `RD_REQ` asserted together and held; bench `STATUS` busy for 4 cycles each → service order GEIG, MAG, RD, GEIG…; one DONE pulse per command; `ROW_OUT` matches each requester.
- Refresh becomes due while MAG is in WAIT_DONE → MAG completes, refresh issues next, then the round-robin continues with RD.
- `STATUS` held at 1 after a WRITE issue → after 15 cycles `CMD_ERROR`=1, `CMD_OUT`=00, no `GEIG_DONE`; the request is re-issued once `STATUS` behaves.
- `STATUS` held at 0 for 8×360 cycles → `REFRESH_OVERRUN`=1 and pending=7; after release, 7 back-to-back REFRESH commands before any requester is served.
- `RESET` asserted during WAIT_DONE of a READ → next cycle state IDLE, `CMD_OUT`=00, `RD_DONE` never pulses.
